// File: rtl/bus_arbiter_if.sv
// Request, grant, response and downstream bus signals of the two-requester bus arbiter.
// The slave modport is the arbiter's view; master is the requester/bus-side view.
interface bus_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_bytemask;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        bus_ren;
    logic [31:0] bus_raddr;
    logic        bus_wen;
    logic [31:0] bus_waddr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_bytemask;
    logic [31:0] bus_rdata;

    modport slave (
        input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_bytemask, bus_rdata,
        output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
               bus_ren, bus_raddr, bus_wen, bus_waddr, bus_wdata, bus_bytemask
    );

    modport master (
        output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_bytemask, bus_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
               bus_ren, bus_raddr, bus_wen, bus_waddr, bus_wdata, bus_bytemask
    );
endinterface

// File: rtl/bus_arbiter.sv
// Fetch/data arbiter for the single system bus port, with starvation protection for fetch.
// Define BUS_ARB_RR_EN for round-robin priority instead of fixed data-over-fetch priority.
module bus_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_arbiter_if.slave   arb
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_r;
    logic [CNT_W-1:0] starve_cnt_s;
    logic             rd_pend_r;
    logic             rd_sel_r;
    logic [31:0]      raddr_r;
    logic [31:0]      waddr_r;
    logic [31:0]      wdata_r;
    logic [3:0]       bytemask_r;
    logic             force_m0_s;
    logic             pick_m1_s;
    logic             m0_gnt_s;
    logic             m1_gnt_s;
`ifdef BUS_ARB_RR_EN
    logic             last_gnt_r;
`endif

    // Arbitration: starvation forcing first, then the configured priority rule
    always_comb begin
        force_m0_s = 1'b0;
        pick_m1_s  = 1'b0;
        if ((STARVE_MAX > 0) && arb.m0_req && (starve_cnt_r == STARVE_LIM)) begin
            force_m0_s = 1'b1;
        end else begin
            force_m0_s = 1'b0;
        end
        if (force_m0_s) begin
            pick_m1_s = 1'b0;
`ifdef BUS_ARB_RR_EN
        end else if (arb.m1_req && arb.m0_req) begin
            pick_m1_s = ~last_gnt_r;
`endif
        end else begin
            pick_m1_s = arb.m1_req;
        end
        // Grants are suppressed while reset is held low
        m1_gnt_s = rst_n & pick_m1_s;
        m0_gnt_s = rst_n & arb.m0_req & ~pick_m1_s;
    end

    // Downstream drive; address/data fall back to the last issued values when idle
    always_comb begin
        arb.bus_ren      = 1'b0;
        arb.bus_wen      = 1'b0;
        arb.bus_raddr    = raddr_r;
        arb.bus_waddr    = waddr_r;
        arb.bus_wdata    = wdata_r;
        arb.bus_bytemask = bytemask_r;
        if (m0_gnt_s) begin
            arb.bus_ren   = 1'b1;
            arb.bus_raddr = arb.m0_addr;
        end else if (m1_gnt_s && !arb.m1_we) begin
            arb.bus_ren   = 1'b1;
            arb.bus_raddr = arb.m1_addr;
        end else if (m1_gnt_s) begin
            arb.bus_wen      = 1'b1;
            arb.bus_waddr    = arb.m1_addr;
            arb.bus_wdata    = arb.m1_wdata;
            arb.bus_bytemask = arb.m1_bytemask;
        end else begin
            arb.bus_ren = 1'b0;
            arb.bus_wen = 1'b0;
        end
    end

    // Next starvation count: saturating count of consecutive denied fetch cycles
    always_comb begin
        starve_cnt_s = {CNT_W{1'b0}};
        if (arb.m0_req && !m0_gnt_s) begin
            if (starve_cnt_r == STARVE_LIM) begin
                starve_cnt_s = starve_cnt_r;
            end else begin
                starve_cnt_s = starve_cnt_r + CNT_W'(1);
            end
        end else begin
            starve_cnt_s = {CNT_W{1'b0}};
        end
    end

    // Control state: pending-read tracking and starvation counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_r    <= 1'b0;
            rd_sel_r     <= 1'b0;
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            rd_pend_r    <= m0_gnt_s | (m1_gnt_s & ~arb.m1_we);
            starve_cnt_r <= starve_cnt_s;
            if (m0_gnt_s) begin
                rd_sel_r <= 1'b0;
            end else if (m1_gnt_s && !arb.m1_we) begin
                rd_sel_r <= 1'b1;
            end else begin
                rd_sel_r <= rd_sel_r;
            end
        end
    end

    // Hold registers for the idle-cycle bus address/data values (datapath, not reset)
    always_ff @(posedge clk) begin
        if (arb.bus_ren) begin
            raddr_r <= arb.bus_raddr;
        end else begin
            raddr_r <= raddr_r;
        end
        if (arb.bus_wen) begin
            waddr_r    <= arb.bus_waddr;
            wdata_r    <= arb.bus_wdata;
            bytemask_r <= arb.bus_bytemask;
        end else begin
            waddr_r    <= waddr_r;
            wdata_r    <= wdata_r;
            bytemask_r <= bytemask_r;
        end
    end

`ifdef BUS_ARB_RR_EN
    // Most recently granted requester, used to alternate on contention
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_r <= 1'b0;
        end else if (m0_gnt_s || m1_gnt_s) begin
            last_gnt_r <= m1_gnt_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end
`endif

    assign arb.m0_gnt    = m0_gnt_s;
    assign arb.m1_gnt    = m1_gnt_s;
    assign arb.m0_rvalid = rd_pend_r & ~rd_sel_r;
    assign arb.m1_rvalid = rd_pend_r & rd_sel_r;
    assign arb.m0_rdata  = arb.bus_rdata;
    assign arb.m1_rdata  = arb.bus_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected grants/responses by cycle,
// a negedge monitor pops and compares them against what the arbiter presents.
module tb_bus_arbiter;

    logic clk;
    logic rst_n;
    int   cyc;
    bit   done;
    int   n_cmp;
    int   n_bad;

    bus_arbiter_if bif ();

    bus_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bif)
    );

`ifdef BUS_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        int          who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bm;
    } gnt_t;

    typedef struct {
        int          cyc;
        int          who;
        logic [31:0] data;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];

    int fix_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int rr_seq  [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic set_in(input logic r0, input logic [31:0] a0, input logic r1, input logic we,
                          input logic [31:0] a1, input logic [31:0] wd, input logic [3:0] bm,
                          input logic [31:0] rd);
        bif.m0_req      = r0;
        bif.m0_addr     = a0;
        bif.m1_req      = r1;
        bif.m1_we       = we;
        bif.m1_addr     = a1;
        bif.m1_wdata    = wd;
        bif.m1_bytemask = bm;
        bif.bus_rdata   = rd;
    endtask

    task automatic exp_gnt(input int who, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] bm);
        gnt_t g;
        g.cyc = cyc; g.who = who; g.we = we; g.addr = addr; g.wdata = wd; g.bm = bm;
        gq.push_back(g);
    endtask

    task automatic exp_rd(input int who, input logic [31:0] data);
        rsp_t r;
        r.cyc = cyc + 1; r.who = who; r.data = data;
        rq.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus: directed vectors with hand-computed expectations
    initial begin
        int who;
        cyc   = 0;
        done  = 1'b0;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        set_in(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        // Release: m1 wins the first contended cycle
        rst_n = 1'b1;
        set_in(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'h0, 32'h0);
        exp_gnt(1, 1'b0, 32'h3000_0000, 32'h0, 4'h0);
        exp_rd(1, 32'h1111_1111);
        tick();
        // Single fetch
        set_in(1'b1, 32'h1000_0010, 1'b0, 1'b0, 32'h3000_0000, 32'h0, 4'h0, 32'h1111_1111);
        exp_gnt(0, 1'b0, 32'h1000_0010, 32'h0, 4'h0);
        exp_rd(0, 32'hDEAD_BEEF);
        tick();
        set_in(1'b0, 32'h1000_0010, 1'b0, 1'b0, 32'h3000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF);
        tick();
        // Write pass-through, then an idle cycle that must not raise rvalid
        set_in(1'b0, 32'h1000_0010, 1'b1, 1'b1, 32'h2000_0000, 32'h0000_0041, 4'h1, 32'h5555_AAAA);
        exp_gnt(1, 1'b1, 32'h2000_0000, 32'h0000_0041, 4'h1);
        tick();
        set_in(1'b0, 32'h1000_0010, 1'b0, 1'b0, 32'h2000_0000, 32'h0, 4'h0, 32'h1234_5678);
        tick();
        // Fetch to clear the starvation count and make m0 the last grant
        set_in(1'b1, 32'h1000_0020, 1'b0, 1'b0, 32'h3000_0040, 32'h0, 4'h0, 32'h0);
        exp_gnt(0, 1'b0, 32'h1000_0020, 32'h0, 4'h0);
        exp_rd(0, 32'hC0DE_0000);
        tick();
        // Contention: both requesters held for 10 cycles
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'h1000_0020, 1'b1, 1'b0, 32'h3000_0040, 32'h0, 4'h0, 32'hC0DE_0000 + 32'(i));
            who = RR_EN ? rr_seq[i] : fix_seq[i];
            exp_gnt(who, 1'b0, (who == 1) ? 32'h3000_0040 : 32'h1000_0020, 32'h0, 4'h0);
            exp_rd(who, 32'hC0DE_0000 + 32'(i + 1));
            tick();
        end
        // Interleaved single-requester reads, one per cycle
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                set_in(1'b1, 32'h1000_0100 + 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hC0DE_000A + 32'(i));
                exp_gnt(0, 1'b0, 32'h1000_0100 + 32'(i * 4), 32'h0, 4'h0);
                exp_rd(0, 32'hC0DE_000A + 32'(i + 1));
            end else begin
                set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000_0100 + 32'(i * 4), 32'h0, 4'h0, 32'hC0DE_000A + 32'(i));
                exp_gnt(1, 1'b0, 32'h3000_0100 + 32'(i * 4), 32'h0, 4'h0);
                exp_rd(1, 32'hC0DE_000A + 32'(i + 1));
            end
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hC0DE_0010);
        tick();
        // Reset right behind a read: response already pending shows, nothing afterwards
        set_in(1'b1, 32'h1000_0200, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        exp_gnt(0, 1'b0, 32'h1000_0200, 32'h0, 4'h0);
        exp_rd(0, 32'h7777_0001);
        tick();
        rst_n = 1'b0;
        set_in(1'b1, 32'h1000_0200, 1'b1, 1'b0, 32'h3000_0200, 32'h0, 4'h0, 32'h7777_0001);
        tick();
        set_in(1'b1, 32'h1000_0200, 1'b1, 1'b0, 32'h3000_0200, 32'h0, 4'h0, 32'h7777_0002);
        tick();
        rst_n = 1'b1;
        set_in(1'b1, 32'h1000_0300, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h7777_0003);
        exp_gnt(0, 1'b0, 32'h1000_0300, 32'h0, 4'h0);
        exp_rd(0, 32'h7777_0004);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h7777_0004);
        tick();
        @(negedge clk);
        #1;
        done = 1'b1;
    end

    // Monitor: compares every cycle at the falling edge, then prints the summary
    initial begin
        logic        g0, g1, r0, r1, exp_g, exp_r;
        logic        raddr_known, waddr_known;
        logic [31:0] last_raddr, last_waddr;
        gnt_t        ge;
        rsp_t        re;
        raddr_known = 1'b0;
        waddr_known = 1'b0;
        last_raddr  = 32'h0;
        last_waddr  = 32'h0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (done) break;
            g0 = bif.m0_gnt; g1 = bif.m1_gnt;
            r0 = bif.m0_rvalid; r1 = bif.m1_rvalid;
            chk("gnt_onehot", {31'b0, g0 & g1}, 32'h0);
            chk("rvalid_onehot", {31'b0, r0 & r1}, 32'h0);
            exp_g = (gq.size() > 0) && (gq[0].cyc == cyc);
            chk("gnt_present", {31'b0, g0 | g1}, {31'b0, exp_g});
            if (exp_g) begin
                ge = gq.pop_front();
                chk("gnt_who", {31'b0, g1}, 32'(ge.who));
                chk("bus_ren", {31'b0, bif.bus_ren}, {31'b0, ~ge.we});
                chk("bus_wen", {31'b0, bif.bus_wen}, {31'b0, ge.we});
                if (ge.we) begin
                    chk("bus_waddr", bif.bus_waddr, ge.addr);
                    chk("bus_wdata", bif.bus_wdata, ge.wdata);
                    chk("bus_bytemask", {28'h0, bif.bus_bytemask}, {28'h0, ge.bm});
                    last_waddr  = ge.addr;
                    waddr_known = 1'b1;
                end else begin
                    chk("bus_raddr", bif.bus_raddr, ge.addr);
                    last_raddr  = ge.addr;
                    raddr_known = 1'b1;
                end
            end else begin
                chk("idle_ren_wen", {30'h0, bif.bus_ren, bif.bus_wen}, 32'h0);
                if (raddr_known) chk("hold_raddr", bif.bus_raddr, last_raddr);
                if (waddr_known) chk("hold_waddr", bif.bus_waddr, last_waddr);
            end
            exp_r = (rq.size() > 0) && (rq[0].cyc == cyc);
            chk("rvalid_present", {31'b0, r0 | r1}, {31'b0, exp_r});
            if (exp_r) begin
                re = rq.pop_front();
                chk("rvalid_who", {31'b0, r1}, 32'(re.who));
                chk("rdata", (re.who == 1) ? bif.m1_rdata : bif.m0_rdata, re.data);
            end
        end
        chk("gnt_queue_left", 32'(gq.size()), 32'h0);
        chk("rsp_queue_left", 32'(rq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
